heat_grid_engine: RTL and testbench
===================================

Name: heat_grid_engine

Overview:
- Parametrised NCOLS x NROWS explicit heat/diffusion grid engine; successor to the fixed 30-column grid generator.
- Holds the grid in per-column register storage. All columns update in parallel, one row per cycle, for a programmable number of time steps.
- New capabilities: selectable boundary mode, a pinned heat-source cell, a start/busy/done handshake, and a registered random-access readout port for the VGA renderer.

Parameters:
NCOLS, 30, number of columns (>=2)
NROWS, 30, number of rows (>=2)
W, 32, signed fixed-point word width
FRAC, 27, fractional bits (1.0 = 1<<FRAC)
CW, 5, column index width (>= clog2(NCOLS))
RW, 5, row index width (>= clog2(NROWS))

Ports:
clk_50  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  request a run; sampled only in IDLE
init  in  1  with start: fill grid with init_val instead of stepping
init_val  in  W  fill value for init runs
n_steps  in  16  iterations per step run; 0 is treated as 1
alpha  in  W  signed fixed-point diffusion coefficient
delta  in  W  signed fixed-point time step
bc_mode  in  1  0 = Dirichlet (missing neighbour = 0); 1 = Neumann (missing neighbour = own centre value)
src_en  in  1  enable pinned source cell
src_col  in  CW  source column
src_row  in  RW  source row
src_val  in  W  source value
busy  out  1  run in progress
done  out  1  one-cycle pulse when a run completes
rd_col  in  CW  readout column
rd_row  in  RW  readout row
rd_data  out  W  registered readout data

Behaviour:
- Reset (async): state IDLE; busy=0; done=0; rd_data=0; every cell=0; ad_reg=0; counters=0.
- States:
  - IDLE: start&init -> INIT; start&!init -> STEP.
  - INIT: row counter r sweeps 0..NROWS-1.
  - STEP: r sweeps 0..NROWS-1 per iteration; iteration counter k runs 0..n_eff-1.
  - DONE: one cycle -> IDLE.
- On accepted start (cycle 0): latch ad_reg = (alpha*delta)>>>FRAC (truncated to W bits), n_eff = max(n_steps,1), bc_mode, src_*. Inputs changing mid-run have no effect.
- busy=1 from cycle 1 until the DONE cycle.
- INIT: at cycle 1+r, row r of all columns <= init_val. The source cell gets src_val if src_en. done pulses at cycle 1+NROWS.
- STEP, in-place sweep. Cell (c,r) of iteration k is written at cycle 1+k*NROWS+r. done pulses at cycle 1+n_eff*NROWS.
  - Each column keeps prev_old = pre-update value of row r-1.
  - up = prev_old; down = stored row r+1 (not yet updated); left/right = neighbour columns' stored row r (same-cycle, old).
  - Off-grid neighbours are 0 (Dirichlet) or the cell's own old centre (Neumann).
  - lap = left+right+up+down-4*centre, computed in W+3 bits.
  - new = centre + ((lap*ad_reg)>>>FRAC).
  - new saturates to [-2^(W-1), 2^(W-1)-1].
  - The source cell, if src_en, is written src_val instead of new.
- start during busy: ignored, no queueing. done and busy are never high together except in the DONE cycle, where busy=0.
- Readout: rd_data <= cell(rd_col,rd_row), 1-cycle latency, in any state. During STEP it returns current storage, which may be a mix of iteration k and k+1. Out-of-range index returns 0.
- Reset mid-run: immediate return to IDLE, grid cleared, no done pulse.

Decomposition:
- heat_pkg holds W/FRAC defaults, the fixed-point ONE constant, the state encoding (IDLE, INIT, STEP, DONE), BC_DIRICHLET/BC_NEUMANN, and a saturate function.
- Sub-module heat_column: one column's NROWS-word storage, prev_old register, laplacian/update datapath and source override. It is instanced NCOLS times by a generate loop.
- The top level owns the FSM, counters, ad_reg latch and readout mux.

Test Plan (NCOLS=NROWS=4, W=32, FRAC=27, 1.0=0x0800_0000):
1. Release reset, no start -> busy=0, done=0; rd_data=0 for all 16 cells.
2. start,init=1,init_val=0x0800_0000 at cycle 0 -> busy cycles 1..4, done pulse at cycle 5, all cells read 0x0800_0000.
3. After test 2, bc_mode=1, alpha=0.8 (0x0666_6666), delta=0.1 (0x00CC_CCCC), n_steps=5 -> done at cycle 21; every cell still 0x0800_0000 ±1 LSB.
4. init with init_val=0, src_en at (1,1)=1.0, then one Dirichlet step, same alpha/delta:
   - (1,1) = 0x0800_0000.
   - (0,1), (2,1), (1,0), (1,2) ≈ 0.08 = 0x00A3_D70A ±2 LSB.
   - (0,0) = 0.
5. init all 8.0 (0x4000_0000), alpha=-1.0, delta=1.0, Dirichlet, 1 step -> corner (0,0) reads 0x7FFF_FFFF (saturated).
6. start step run n_steps=0 with start pulsed again at cycle 2 -> exactly one done at cycle 5. A second run with reset asserted at cycle 3 -> busy=0 at once, no done, all cells 0.

Source files
------------

// File: rtl/heat_pkg.sv
// Shared fixed-point constants, FSM state encoding and the saturation helper
// for the heat grid engine.
package heat_pkg;

    localparam int unsigned W_DEF    = 32;
    localparam int unsigned FRAC_DEF = 27;
    localparam logic [W_DEF-1:0] ONE = W_DEF'(1) << FRAC_DEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        STEP = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic BC_DIRICHLET = 1'b0;
    localparam logic BC_NEUMANN   = 1'b1;

    // Wide enough for the (W+3)*W product plus centre for any W up to 62.
    localparam int unsigned SAT_XW = 128;

    // Clamp a wide signed value into the signed range of a w-bit word.
    function automatic logic signed [SAT_XW-1:0] saturate(
        input logic signed [SAT_XW-1:0] x,
        input int unsigned              w
    );
        logic signed [SAT_XW-1:0] hi;
        logic signed [SAT_XW-1:0] lo;
        hi = $signed((SAT_XW'(1) << (w - 1)) - SAT_XW'(1));
        lo = ~hi;
        if (x > hi)      return hi;
        else if (x < lo) return lo;
        else             return x;
    endfunction

endpackage

// File: rtl/heat_column.sv
// One grid column: row storage, in-place sweep datapath with boundary handling,
// pinned source override and a combinational readout word.
module heat_column
    import heat_pkg::*;
#(
    parameter int unsigned NROWS = 30,
    parameter int unsigned W     = 32,
    parameter int unsigned FRAC  = 27,
    parameter int unsigned RW    = 5
) (
    input  logic          clk_50,
    input  logic          reset,
    input  logic [RW-1:0] row,
    input  logic          init_we,
    input  logic          step_we,
    input  logic [W-1:0]  init_val,
    input  logic [W-1:0]  ad,
    input  logic          bc_mode,
    input  logic          left_en,
    input  logic          right_en,
    input  logic [W-1:0]  left_val,
    input  logic [W-1:0]  right_val,
    input  logic          src_hit,
    input  logic [RW-1:0] src_row,
    input  logic [W-1:0]  src_val,
    input  logic [RW-1:0] rd_row,
    output logic [W-1:0]  centre_c,
    output logic [W-1:0]  rd_word_c
);

    localparam int unsigned RIW = (NROWS > 1) ? $clog2(NROWS) : 1;
    localparam logic [RW-1:0] LAST = RW'(NROWS - 1);

    logic [W-1:0] mem [NROWS];
    logic [W-1:0] prev_old;

    logic [RIW-1:0]           cur_idx;
    logic [RIW-1:0]           dn_idx;
    logic signed [W-1:0]      centre;
    logic signed [W-1:0]      bc_v;
    logic signed [W-1:0]      up_v;
    logic signed [W-1:0]      dn_v;
    logic signed [W-1:0]      lf_v;
    logic signed [W-1:0]      rt_v;
    logic signed [W+2:0]      lap;
    logic signed [2*W+2:0]    prod;
    logic signed [2*W+2:0]    upd;
    logic signed [SAT_XW-1:0] sum;
    logic signed [W-1:0]      new_v;
    logic [W-1:0]             wr_val;

    // Laplacian update: every neighbour is the pre-update value of this sweep.
    always_comb begin
        cur_idx  = RIW'(row);
        dn_idx   = (row == LAST) ? RIW'(row) : RIW'(row + RW'(1));
        centre   = $signed(mem[cur_idx]);
        bc_v     = (bc_mode == BC_NEUMANN) ? centre : '0;
        up_v     = (row == '0)   ? bc_v : $signed(prev_old);
        dn_v     = (row == LAST) ? bc_v : $signed(mem[dn_idx]);
        lf_v     = left_en  ? $signed(left_val)  : bc_v;
        rt_v     = right_en ? $signed(right_val) : bc_v;
        lap      = (W+3)'(lf_v) + (W+3)'(rt_v) + (W+3)'(up_v) + (W+3)'(dn_v)
                 - ((W+3)'(centre) <<< 2);
        prod     = (2*W+3)'(lap) * (2*W+3)'($signed(ad));
        upd      = prod >>> FRAC;
        sum      = SAT_XW'(upd) + SAT_XW'(centre);
        new_v    = W'(saturate(sum, W));
        centre_c = mem[cur_idx];
        if (src_hit && (row == src_row)) wr_val = src_val;
        else if (init_we)                wr_val = init_val;
        else                             wr_val = new_v;
        rd_word_c = (32'(rd_row) < NROWS) ? mem[RIW'(rd_row)] : '0;
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(NROWS); i++) mem[i] <= '0;
            prev_old <= '0;
        end else if (init_we || step_we) begin
            mem[cur_idx] <= wr_val;
            if (step_we) prev_old <= centre_c;
        end
    end

endmodule

// File: rtl/heat_grid_engine.sv
// Heat/diffusion grid engine top: run FSM, sweep counters, latched run
// parameters, column array and registered random-access readout.
module heat_grid_engine
    import heat_pkg::*;
#(
    parameter int unsigned NCOLS = 30,
    parameter int unsigned NROWS = 30,
    parameter int unsigned W     = W_DEF,
    parameter int unsigned FRAC  = FRAC_DEF,
    parameter int unsigned CW    = 5,
    parameter int unsigned RW    = 5
) (
    input  logic          clk_50,
    input  logic          reset,
    input  logic          start,
    input  logic          init,
    input  logic [W-1:0]  init_val,
    input  logic [15:0]   n_steps,
    input  logic [W-1:0]  alpha,
    input  logic [W-1:0]  delta,
    input  logic          bc_mode,
    input  logic          src_en,
    input  logic [CW-1:0] src_col,
    input  logic [RW-1:0] src_row,
    input  logic [W-1:0]  src_val,
    output logic          busy,
    output logic          done,
    input  logic [CW-1:0] rd_col,
    input  logic [RW-1:0] rd_row,
    output logic [W-1:0]  rd_data
);

    localparam int unsigned CIW = (NCOLS > 1) ? $clog2(NCOLS) : 1;
    localparam logic [RW-1:0] LAST_ROW = RW'(NROWS - 1);

    state_t        state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [15:0]   iter_q, iter_d;
    logic [15:0]   n_eff_q;
    logic [W-1:0]  ad_q;
    logic [W-1:0]  init_val_q;
    logic          bc_q;
    logic          src_en_q;
    logic [CW-1:0] src_col_q;
    logic [RW-1:0] src_row_q;
    logic [W-1:0]  src_val_q;
    logic          busy_d, done_d;
    logic          accept;
    logic          init_we, step_we;

    logic signed [2*W-1:0] ad_prod;
    logic [W-1:0]          ad_next;

    logic [W-1:0] col_cen [NCOLS];
    logic [W-1:0] col_rd  [NCOLS];

    // Next-state, counter and handshake logic.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        iter_d  = iter_q;
        accept  = 1'b0;
        init_we = 1'b0;
        step_we = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    row_d   = '0;
                    iter_d  = '0;
                    state_d = init ? INIT : STEP;
                end
            end
            INIT: begin
                init_we = 1'b1;
                if (row_q == LAST_ROW) begin
                    row_d   = '0;
                    state_d = DONE;
                end else begin
                    row_d = row_q + RW'(1);
                end
            end
            STEP: begin
                step_we = 1'b1;
                if (row_q == LAST_ROW) begin
                    row_d = '0;
                    if (iter_q == n_eff_q - 16'd1) begin
                        iter_d  = '0;
                        state_d = DONE;
                    end else begin
                        iter_d = iter_q + 16'd1;
                    end
                end else begin
                    row_d = row_q + RW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d  = (state_d == INIT) || (state_d == STEP);
        done_d  = (state_d == DONE);
        ad_prod = (2*W)'($signed(alpha)) * (2*W)'($signed(delta));
        ad_next = W'(ad_prod >>> FRAC);
    end

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            row_q      <= '0;
            iter_q     <= '0;
            n_eff_q    <= '0;
            ad_q       <= '0;
            init_val_q <= '0;
            bc_q       <= 1'b0;
            src_en_q   <= 1'b0;
            src_col_q  <= '0;
            src_row_q  <= '0;
            src_val_q  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            rd_data    <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            iter_q  <= iter_d;
            busy    <= busy_d;
            done    <= done_d;
            rd_data <= (32'(rd_col) < NCOLS) ? col_rd[CIW'(rd_col)] : '0;
            if (accept) begin
                n_eff_q    <= (n_steps == 16'd0) ? 16'd1 : n_steps;
                ad_q       <= ad_next;
                init_val_q <= init_val;
                bc_q       <= bc_mode;
                src_en_q   <= src_en;
                src_col_q  <= src_col;
                src_row_q  <= src_row;
                src_val_q  <= src_val;
            end
        end
    end

    // Column array; each column sees its neighbours' stored row of this cycle.
    for (genvar c = 0; c < int'(NCOLS); c++) begin : g_col
        logic [W-1:0] lf_w;
        logic [W-1:0] rt_w;

        if (c > 0) begin : g_lf
            assign lf_w = col_cen[c-1];
        end else begin : g_lf_edge
            assign lf_w = '0;
        end

        if (c < int'(NCOLS) - 1) begin : g_rt
            assign rt_w = col_cen[c+1];
        end else begin : g_rt_edge
            assign rt_w = '0;
        end

        heat_column #(
            .NROWS (NROWS),
            .W     (W),
            .FRAC  (FRAC),
            .RW    (RW)
        ) u_col (
            .clk_50    (clk_50),
            .reset     (reset),
            .row       (row_q),
            .init_we   (init_we),
            .step_we   (step_we),
            .init_val  (init_val_q),
            .ad        (ad_q),
            .bc_mode   (bc_q),
            .left_en   (c > 0),
            .right_en  (c < int'(NCOLS) - 1),
            .left_val  (lf_w),
            .right_val (rt_w),
            .src_hit   (src_en_q && (src_col_q == CW'(c))),
            .src_row   (src_row_q),
            .src_val   (src_val_q),
            .rd_row    (rd_row),
            .centre_c  (col_cen[c]),
            .rd_word_c (col_rd[c])
        );
    end

endmodule

// File: tb/tb_heat_grid_engine.sv
// Scoreboard bench for heat_grid_engine on a 4x4 grid: a Jacobi-style grid
// model predicts readouts, done timing and busy windows.
module tb_heat_grid_engine;

    localparam int NC = 4;
    localparam int NR = 4;

    logic        clk_50 = 1'b0;
    logic        reset;
    logic        start, init, bc_mode, src_en;
    logic [31:0] init_val, alpha, delta, src_val;
    logic [15:0] n_steps;
    logic [2:0]  src_col, src_row, rd_col, rd_row;
    logic        busy, done;
    logic [31:0] rd_data;

    heat_grid_engine #(
        .NCOLS(NC), .NROWS(NR), .W(32), .FRAC(27), .CW(3), .RW(3)
    ) dut (
        .clk_50   (clk_50),
        .reset    (reset),
        .start    (start),
        .init     (init),
        .init_val (init_val),
        .n_steps  (n_steps),
        .alpha    (alpha),
        .delta    (delta),
        .bc_mode  (bc_mode),
        .src_en   (src_en),
        .src_col  (src_col),
        .src_row  (src_row),
        .src_val  (src_val),
        .busy     (busy),
        .done     (done),
        .rd_col   (rd_col),
        .rd_row   (rd_row),
        .rd_data  (rd_data)
    );

    always #10 clk_50 = ~clk_50;

    typedef struct {
        int          c;
        int          r;
        logic [31:0] v;
    } rd_exp_t;

    rd_exp_t rd_q[$];
    int      done_q[$];
    int      cyc     = 0;
    int      busy_lo = 1;
    int      busy_hi = 0;
    int      n_cmp   = 0;
    int      n_err   = 0;
    logic    rd_req  = 1'b0;
    logic    rd_vld  = 1'b0;

    logic signed [31:0] g [NC][NR];

    always @(posedge clk_50) begin
        cyc    <= cyc + 1;
        rd_vld <= rd_req;
    end

    // Monitor: compares busy every cycle, each done pulse and each readout.
    always @(negedge clk_50) begin
        logic exp_busy;
        rd_exp_t e;
        exp_busy = (cyc >= busy_lo) && (cyc <= busy_hi);
        n_cmp++;
        if (busy !== exp_busy) begin
            n_err++;
            $display("FAIL busy @cyc %0d: got %b want %b", cyc, busy, exp_busy);
        end
        if (done === 1'b1) begin
            n_cmp++;
            if (done_q.size() == 0) begin
                n_err++;
                $display("FAIL done @cyc %0d: got unexpected pulse want none", cyc);
            end else begin
                int ec;
                ec = done_q.pop_front();
                if (ec != cyc) begin
                    n_err++;
                    $display("FAIL done cycle: got %0d want %0d", cyc, ec);
                end
            end
        end
        if (rd_vld) begin
            n_cmp++;
            if (rd_q.size() == 0) begin
                n_err++;
                $display("FAIL rd: got %h want no readout pending", rd_data);
            end else begin
                e = rd_q.pop_front();
                if (rd_data !== e.v) begin
                    n_err++;
                    $display("FAIL rd(%0d,%0d): got %h want %h", e.c, e.r, rd_data, e.v);
                end
            end
        end
    end

    function automatic logic signed [31:0] sat32(input logic signed [127:0] x);
        if (x > 128'sh7FFF_FFFF)        return 32'sh7FFF_FFFF;
        else if (x < -128'sh8000_0000)  return 32'sh8000_0000;
        else                            return x[31:0];
    endfunction

    // Every neighbour in a sweep is a pre-update value, so one iteration is a
    // plain copy-then-update of the whole grid.
    task automatic model_run(input bit ini, input int ns);
        logic signed [31:0]  old [NC][NR];
        logic signed [63:0]  p64;
        logic signed [127:0] ad, cen, l, rr, u, d, lap, t;
        int n;
        p64 = longint'($signed(alpha)) * longint'($signed(delta));
        ad  = $signed(p64 >>> 27) ;
        ad  = 128'($signed(ad[31:0]));
        n   = (ns == 0) ? 1 : ns;
        if (ini) begin
            for (int c = 0; c < NC; c++)
                for (int r = 0; r < NR; r++) g[c][r] = $signed(init_val);
            if (src_en) g[src_col][src_row] = $signed(src_val);
        end else begin
            for (int it = 0; it < n; it++) begin
                old = g;
                for (int c = 0; c < NC; c++) begin
                    for (int r = 0; r < NR; r++) begin
                        cen = old[c][r];
                        l   = (c > 0)      ? 128'(old[c-1][r]) : (bc_mode ? cen : 128'sd0);
                        rr  = (c < NC - 1) ? 128'(old[c+1][r]) : (bc_mode ? cen : 128'sd0);
                        u   = (r > 0)      ? 128'(old[c][r-1]) : (bc_mode ? cen : 128'sd0);
                        d   = (r < NR - 1) ? 128'(old[c][r+1]) : (bc_mode ? cen : 128'sd0);
                        lap = l + rr + u + d - 128'sd4 * cen;
                        t   = ((lap * ad) >>> 27) + cen;
                        g[c][r] = sat32(t);
                        if (src_en && (src_col == 3'(c)) && (src_row == 3'(r)))
                            g[c][r] = $signed(src_val);
                    end
                end
            end
        end
    endtask

    task automatic cfg(input logic [31:0] a, input logic [31:0] dt, input bit bc,
                       input bit se, input int sc, input int sr,
                       input logic [31:0] sv, input logic [31:0] iv);
        alpha = a; delta = dt; bc_mode = bc; src_en = se;
        src_col = 3'(sc); src_row = 3'(sr); src_val = sv; init_val = iv;
    endtask

    // Issue one run at the current cycle; pulse_at re-raises start mid-run.
    task automatic run_job(input bit ini, input int ns, input int pulse_at);
        int len, c0;
        start = 1'b1; init = ini; n_steps = 16'(ns);
        c0  = cyc;
        len = ini ? NR : (((ns == 0) ? 1 : ns) * NR);
        busy_lo = c0 + 1;
        busy_hi = c0 + len;
        done_q.push_back(c0 + len + 1);
        model_run(ini, ns);
        for (int i = 1; i <= len + 2; i++) begin
            @(posedge clk_50); #1;
            start = (i == pulse_at);
            if (i == 1) begin
                alpha = $urandom; delta = $urandom; init_val = $urandom;
                bc_mode = 1'($urandom); src_en = 1'($urandom);
                src_col = 3'($urandom); src_row = 3'($urandom);
                src_val = $urandom; n_steps = 16'($urandom); init = 1'($urandom);
            end
        end
        start = 1'b0;
    endtask

    task automatic read_cell(input int c, input int r);
        rd_exp_t e;
        rd_col = 3'(c); rd_row = 3'(r);
        e.c = c; e.r = r; e.v = 32'h0;
        if (c < NC && r < NR) e.v = g[c][r];
        rd_q.push_back(e);
        rd_req = 1'b1;
        @(posedge clk_50); #1;
    endtask

    task automatic read_all();
        for (int c = 0; c < NC; c++)
            for (int r = 0; r < NR; r++) read_cell(c, r);
        read_cell(4, 0);
        read_cell(0, 5);
        read_cell(7, 7);
        rd_req = 1'b0;
        repeat (2) @(posedge clk_50);
        #1;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; init = 1'b0; n_steps = '0;
        rd_col = '0; rd_row = '0;
        cfg(32'h0, 32'h0, 1'b0, 1'b0, 0, 0, 32'h0, 32'h0);
        for (int c = 0; c < NC; c++)
            for (int r = 0; r < NR; r++) g[c][r] = '0;
        repeat (3) @(posedge clk_50);
        #1 reset = 1'b0;
        @(posedge clk_50); #1;

        // Cleared grid after reset.
        read_all();

        // Fill with 1.0, then Neumann steps keep the grid uniform.
        cfg(32'h0666_6666, 32'h00CC_CCCC, 1'b1, 1'b0, 0, 0, 32'h0, 32'h0800_0000);
        run_job(1'b1, 0, -1);
        read_all();
        cfg(32'h0666_6666, 32'h00CC_CCCC, 1'b1, 1'b0, 0, 0, 32'h0, 32'h0800_0000);
        run_job(1'b0, 5, -1);
        read_all();

        // Point source at (1,1) in a zero grid, one Dirichlet step.
        cfg(32'h0666_6666, 32'h00CC_CCCC, 1'b0, 1'b1, 1, 1, 32'h0800_0000, 32'h0);
        run_job(1'b1, 0, -1);
        cfg(32'h0666_6666, 32'h00CC_CCCC, 1'b0, 1'b1, 1, 1, 32'h0800_0000, 32'h0);
        run_job(1'b0, 1, -1);
        read_all();

        // Negative coefficient on a hot grid drives the corner to saturation.
        cfg(32'hF800_0000, 32'h0800_0000, 1'b0, 1'b0, 0, 0, 32'h0, 32'h4000_0000);
        run_job(1'b1, 0, -1);
        cfg(32'hF800_0000, 32'h0800_0000, 1'b0, 1'b0, 0, 0, 32'h0, 32'h4000_0000);
        run_job(1'b0, 1, -1);
        read_all();

        // n_steps=0 runs once; a second start mid-run is ignored.
        cfg(32'h0666_6666, 32'h00CC_CCCC, 1'b0, 1'b0, 0, 0, 32'h0, 32'h0);
        run_job(1'b0, 0, 2);
        read_all();

        // Reset during a run: busy drops at once, no done, grid cleared.
        begin
            int c0;
            cfg(32'h0666_6666, 32'h00CC_CCCC, 1'b0, 1'b0, 0, 0, 32'h0, 32'h0);
            start = 1'b1; init = 1'b0; n_steps = 16'd3;
            c0 = cyc;
            busy_lo = c0 + 1;
            busy_hi = c0 + 2;
            @(posedge clk_50); #1 start = 1'b0;
            @(posedge clk_50); #1;
            @(posedge clk_50); #1 reset = 1'b1;
            for (int c = 0; c < NC; c++)
                for (int r = 0; r < NR; r++) g[c][r] = '0;
            @(posedge clk_50); #1 reset = 1'b0;
            @(posedge clk_50); #1;
            read_all();
        end

        // Randomised runs against the model.
        for (int t = 0; t < 10; t++) begin
            logic [31:0] a, dt;
            bit          ini;
            a   = ($urandom_range(0, 3) == 0) ? $urandom : (($urandom & 32'h0FFF_FFFF) - 32'h0800_0000);
            dt  = ($urandom_range(0, 3) == 0) ? $urandom : (($urandom & 32'h0FFF_FFFF) - 32'h0800_0000);
            ini = (t == 0) || ($urandom_range(0, 3) == 0);
            cfg(a, dt, 1'($urandom), 1'($urandom), $urandom_range(0, NC - 1),
                $urandom_range(0, NR - 1), $urandom, $urandom);
            run_job(ini, $urandom_range(0, 3), -1);
            read_all();
        end

        repeat (4) @(posedge clk_50);
        #1;
        n_cmp++;
        if (done_q.size() != 0 || rd_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d done / %0d reads outstanding want 0 / 0",
                     done_q.size(), rd_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
